// File: rtl/ps2_key_decoder_pkg.sv
// Shared constants for the PS/2 game-key decoder:
// scan codes, button bit positions and frame FSM states.
package ps2_key_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_RIGHT = 0;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizers, clock glitch filter,
// 11-bit frame FSM and mid-frame timeout.
module ps2_frame_rx
    import ps2_key_decoder_pkg::*;
#(
    parameter int CLK_FILTER     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       err_o
);

    localparam int FW = $clog2(CLK_FILTER + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    cs_q, ds_q;
    logic          flt_q, flt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0]    shift_q;
    logic [2:0]    bcnt_q;
    logic          par_q;
    rx_state_e     state_q, state_d;
    logic          din, fall, edge_w, timeout, frame_ok;

    assign din = ds_q[1];

    // Filtered clock flips only after CLK_FILTER consecutive differing samples
    always_comb begin
        flt_d  = flt_q;
        fcnt_d = '0;
        if (cs_q[1] != flt_q) begin
            if (fcnt_q == FW'(CLK_FILTER - 1)) flt_d  = cs_q[1];
            else                               fcnt_d = fcnt_q + 1'b1;
        end
    end

    assign fall    = flt_q & ~flt_d;
    assign edge_w  = flt_q ^ flt_d;
    assign timeout = (state_q != ST_IDLE) && !edge_w
                  && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tcnt_d = tcnt_q + 1'b1;
        if (state_q == ST_IDLE || edge_w || timeout) tcnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_q   <= 2'b11;
            ds_q   <= 2'b11;
            flt_q  <= 1'b1;
            fcnt_q <= '0;
            tcnt_q <= '0;
        end else begin
            cs_q   <= {cs_q[0], ps2_clk_i};
            ds_q   <= {ds_q[0], ps2_data_i};
            flt_q  <= flt_d;
            fcnt_q <= fcnt_d;
            tcnt_q <= tcnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = ST_IDLE;
        end else if (fall) begin
            unique case (state_q)
                ST_IDLE:   if (!din) state_d = ST_DATA;
                ST_DATA:   if (bcnt_q == 3'd7) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            bcnt_q  <= '0;
            par_q   <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            bcnt_q  <= '0;
        end else if (fall && state_q == ST_DATA) begin
            shift_q <= {din, shift_q[7:1]};
            bcnt_q  <= bcnt_q + 1'b1;
        end else if (fall && state_q == ST_PARITY) begin
            par_q   <= din;
        end
    end

    always_comb begin
        frame_ok = (^{shift_q, par_q}) & din;
        byte_o   = shift_q;
        valid_o  = fall && (state_q == ST_STOP) && frame_ok;
        err_o    = timeout
                || (fall && state_q == ST_IDLE && din)
                || (fall && state_q == ST_STOP && !frame_ok);
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to game buttons: arrow levels plus
// edge-triggered space/enter pulses with typematic suppression.
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int CLK_FILTER     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [3:0] btns,
    output logic       continue_btn,
    output logic       start_btn,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_err;

    ps2_frame_rx #(
        .CLK_FILTER     (CLK_FILTER),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk_i  (PS2_CLK),
        .ps2_data_i (PS2_DATA),
        .byte_o     (rx_byte),
        .valid_o    (rx_valid),
        .err_o      (rx_err)
    );

    logic [3:0] btns_q, btns_d;
    logic [7:0] code_q, code_d;
    logic       cont_q, cont_d, start_q, start_d;
    logic       sv_q, sv_d, ferr_q, ferr_d;
    logic       ext_q, ext_d, brk_q, brk_d;
    logic       sp_held_q, sp_held_d, en_held_q, en_held_d;

    always_comb begin
        btns_d    = btns_q;
        code_d    = code_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        sp_held_d = sp_held_q;
        en_held_d = en_held_q;
        cont_d    = 1'b0;
        start_d   = 1'b0;
        sv_d      = 1'b0;
        ferr_d    = 1'b0;
        unique case (1'b1)
            rx_err: begin
                ferr_d = 1'b1;
                ext_d  = 1'b0;
                brk_d  = 1'b0;
            end
            rx_valid: begin
                code_d = rx_byte;
                sv_d   = 1'b1;
                if (rx_byte == SC_EXT) begin
                    ext_d = 1'b1;
                end else if (rx_byte == SC_BRK) begin
                    brk_d = 1'b1;
                end else begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                    if (ext_q) begin
                        case (rx_byte)
                            SC_UP:    btns_d[BTN_UP]    = ~brk_q;
                            SC_DOWN:  btns_d[BTN_DOWN]  = ~brk_q;
                            SC_LEFT:  btns_d[BTN_LEFT]  = ~brk_q;
                            SC_RIGHT: btns_d[BTN_RIGHT] = ~brk_q;
                            default:  ;
                        endcase
                    end else if (rx_byte == SC_SPACE) begin
                        // Held flag blocks typematic repeats until a break
                        sp_held_d = ~brk_q;
                        cont_d    = ~brk_q & ~sp_held_q;
                    end else if (rx_byte == SC_ENTER) begin
                        en_held_d = ~brk_q;
                        start_d   = ~brk_q & ~en_held_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btns_q    <= '0;
            code_q    <= '0;
            cont_q    <= 1'b0;
            start_q   <= 1'b0;
            sv_q      <= 1'b0;
            ferr_q    <= 1'b0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            sp_held_q <= 1'b0;
            en_held_q <= 1'b0;
        end else begin
            btns_q    <= btns_d;
            code_q    <= code_d;
            cont_q    <= cont_d;
            start_q   <= start_d;
            sv_q      <= sv_d;
            ferr_q    <= ferr_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            sp_held_q <= sp_held_d;
            en_held_q <= en_held_d;
        end
    end

    assign btns         = btns_q;
    assign continue_btn = cont_q;
    assign start_btn    = start_q;
    assign scan_code    = code_q;
    assign scan_valid   = sv_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: table of frames with a
// scoreboard queue, plus timeout and mid-frame reset sequences.
module tb_ps2_key_decoder;

    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       PS2_CLK, PS2_DATA;
    logic [3:0] btns;
    logic       continue_btn, start_btn, scan_valid, frame_err;
    logic [7:0] scan_code;

    ps2_key_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .PS2_CLK      (PS2_CLK),
        .PS2_DATA     (PS2_DATA),
        .btns         (btns),
        .continue_btn (continue_btn),
        .start_btn    (start_btn),
        .scan_code    (scan_code),
        .scan_valid   (scan_valid),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        logic [3:0] btns;
        bit         cont;
        bit         start;
    } exp_t;

    typedef struct {
        logic [7:0] code;
        bit         bad_par;
        bit         bad_stop;
        logic [3:0] btns;
        bit         cont;
        bit         start;
    } vec_t;

    exp_t q[$];
    vec_t tbl[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every output pulse pops one expected event
    always @(negedge clk) begin
        if (!rst && (scan_valid || frame_err || continue_btn || start_btn)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got sv=%0b err=%0b cont=%0b start=%0b expected none",
                         scan_valid, frame_err, continue_btn, start_btn);
            end else begin
                mon_e = q.pop_front();
                chk("frame_err", 32'(frame_err), 32'(mon_e.is_err));
                chk("scan_valid", 32'(scan_valid), 32'(!mon_e.is_err));
                chk("btns", 32'(btns), 32'(mon_e.btns));
                chk("continue_btn", 32'(continue_btn), 32'(mon_e.cont));
                chk("start_btn", 32'(start_btn), 32'(mon_e.start));
                if (!mon_e.is_err) chk("scan_code", 32'(scan_code), 32'(mon_e.code));
            end
        end
    end

    task automatic push_exp(input bit is_err, input logic [7:0] code,
                            input logic [3:0] b, input bit c, input bit s);
        exp_t e;
        e.is_err = is_err;
        e.code   = code;
        e.btns   = b;
        e.cont   = c;
        e.start  = s;
        q.push_back(e);
    endtask

    task automatic add(input logic [7:0] code, input bit bp, input bit bs,
                       input logic [3:0] b, input bit c, input bit s);
        vec_t v;
        v.code     = code;
        v.bad_par  = bp;
        v.bad_stop = bs;
        v.btns     = b;
        v.cont     = c;
        v.start    = s;
        tbl.push_back(v);
    endtask

    task automatic send_bit(input bit b);
        PS2_DATA = b;
        repeat (HALF) @(posedge clk);
        PS2_CLK = 1'b0;
        repeat (HALF) @(posedge clk);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bp, input bit bs);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ bp);
        send_bit(~bs);
        PS2_DATA = 1'b1;
        repeat (2 * HALF) @(posedge clk);
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (q.size() != 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending events expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        logic [7:0] b75;
        rst      = 1'b1;
        PS2_CLK  = 1'b1;
        PS2_DATA = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_btns", 32'(btns), 32'h0);
        chk("rst_scan_code", 32'(scan_code), 32'h0);
        chk("rst_scan_valid", 32'(scan_valid), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_continue", 32'(continue_btn), 32'h0);
        chk("rst_start", 32'(start_btn), 32'h0);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        add(8'h29, 0, 0, 4'b0000, 1, 0);
        add(8'hE0, 0, 0, 4'b0000, 0, 0);
        add(8'h75, 0, 0, 4'b1000, 0, 0);
        add(8'hE0, 0, 0, 4'b1000, 0, 0);
        add(8'h6B, 0, 0, 4'b1010, 0, 0);
        add(8'hE0, 0, 0, 4'b1010, 0, 0);
        add(8'hF0, 0, 0, 4'b1010, 0, 0);
        add(8'h75, 0, 0, 4'b0010, 0, 0);
        add(8'h5A, 1, 0, 4'b0010, 0, 0);
        add(8'h5A, 0, 0, 4'b0010, 0, 1);
        add(8'h5A, 0, 0, 4'b0010, 0, 0);
        add(8'h5A, 0, 0, 4'b0010, 0, 0);
        add(8'hF0, 0, 0, 4'b0010, 0, 0);
        add(8'h5A, 0, 0, 4'b0010, 0, 0);
        add(8'h5A, 0, 0, 4'b0010, 0, 1);
        add(8'h29, 0, 0, 4'b0010, 0, 0);
        add(8'hF0, 0, 0, 4'b0010, 0, 0);
        add(8'h29, 0, 0, 4'b0010, 0, 0);
        add(8'h29, 0, 0, 4'b0010, 1, 0);
        add(8'hE0, 0, 0, 4'b0010, 0, 0);
        add(8'h74, 0, 0, 4'b0011, 0, 0);
        add(8'hE0, 0, 0, 4'b0011, 0, 0);
        add(8'h72, 0, 0, 4'b0111, 0, 0);
        add(8'hE0, 0, 0, 4'b0111, 0, 0);
        add(8'hF0, 0, 0, 4'b0111, 0, 0);
        add(8'h6B, 0, 0, 4'b0101, 0, 0);
        add(8'hE0, 0, 0, 4'b0101, 0, 0);
        add(8'h1C, 0, 0, 4'b0101, 0, 0);
        add(8'h74, 0, 0, 4'b0101, 0, 0);
        add(8'hE0, 0, 0, 4'b0101, 0, 0);
        add(8'h29, 0, 1, 4'b0101, 0, 0);
        add(8'h6B, 0, 0, 4'b0101, 0, 0);
        add(8'hF0, 0, 0, 4'b0101, 0, 0);
        add(8'h29, 0, 0, 4'b0101, 0, 0);
        add(8'hF0, 0, 0, 4'b0101, 0, 0);
        add(8'h29, 1, 0, 4'b0101, 0, 0);
        add(8'h29, 0, 0, 4'b0101, 1, 0);
        add(8'hF0, 0, 0, 4'b0101, 0, 0);
        add(8'h29, 0, 0, 4'b0101, 0, 0);
        add(8'hE0, 0, 0, 4'b0101, 0, 0);
        add(8'h29, 0, 0, 4'b0101, 0, 0);

        foreach (tbl[i]) begin
            push_exp(tbl[i].bad_par | tbl[i].bad_stop, tbl[i].code,
                     tbl[i].btns, tbl[i].cont, tbl[i].start);
            send_frame(tbl[i].code, tbl[i].bad_par, tbl[i].bad_stop);
            wait_drain(2000);
        end

        // Lone start bit of 1
        push_exp(1, 8'h00, 4'b0101, 0, 0);
        send_bit(1'b1);
        PS2_DATA = 1'b1;
        repeat (2 * HALF) @(posedge clk);
        wait_drain(2000);

        // Clock stalls after four data bits
        push_exp(1, 8'h00, 4'b0101, 0, 0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i == 0 || i == 3);
        PS2_DATA = 1'b1;
        repeat (10001) @(posedge clk);
        wait_drain(3000);
        push_exp(0, 8'h29, 4'b0101, 1, 0);
        send_frame(8'h29, 0, 0);
        wait_drain(2000);

        // Reset during bit 5 of the 0x75 following E0
        push_exp(0, 8'hE0, 4'b0101, 0, 0);
        send_frame(8'hE0, 0, 0);
        wait_drain(2000);
        b75 = 8'h75;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(b75[i]);
        PS2_DATA = b75[5];
        repeat (HALF) @(posedge clk);
        PS2_CLK = 1'b0;
        repeat (5) @(posedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_btns", 32'(btns), 32'h0);
        chk("async_rst_scan_code", 32'(scan_code), 32'h0);
        chk("async_rst_scan_valid", 32'(scan_valid), 32'h0);
        PS2_CLK  = 1'b1;
        PS2_DATA = 1'b1;
        repeat (50) @(posedge clk);
        rst = 1'b0;
        repeat (200) @(posedge clk);
        push_exp(0, 8'h74, 4'b0000, 0, 0);
        send_frame(8'h74, 0, 0);
        wait_drain(2000);
        push_exp(0, 8'h5A, 4'b0000, 0, 1);
        send_frame(8'h5A, 0, 0);
        wait_drain(2000);
        push_exp(0, 8'h29, 4'b0000, 1, 0);
        send_frame(8'h29, 0, 0);
        wait_drain(2000);

        repeat (20) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
